serial_sub_ctrl: RTL and testbench



---
 rtl/sub_pkg.sv | 12 +
 rtl/full_sub_cell.sv | 24 ++
 rtl/serial_sub_ctrl.sv | 113 +++++++++++
 tb/tb_serial_sub_ctrl.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and default width.
package sub_pkg;

  localparam int unsigned DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/full_sub_cell.sv
// One-bit full subtractor built as two cascaded half-subtractor stages with OR-ed borrows.
module full_sub_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic hs1_d;
  logic hs1_b;
  logic hs2_b;

  // first stage: a - b
  assign hs1_d = a ^ b;
  assign hs1_b = ~a & b;

  // second stage: (a - b) - bin
  assign d     = hs1_d ^ bin;
  assign hs2_b = ~hs1_d & bin;

  assign bout  = hs1_b | hs2_b;

endmodule

// File: rtl/serial_sub_ctrl.sv
// Sequencer that computes a - b LSB-first through a single full_sub_cell,
// holding the difference and final borrow until the next completion.
module serial_sub_ctrl
  import sub_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  state_e           state;
  state_e           next_state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic             bflop;
  logic             cell_d;
  logic             cell_bout;
  logic             last_bit;

  full_sub_cell u_cell (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (bflop),
    .d    (cell_d),
    .bout (cell_bout)
  );

  assign last_bit = (cnt == LAST_CNT);

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // next-state logic; start is only honoured in IDLE
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = SHIFT;
      SHIFT:   if (last_bit) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // status flags registered from the upcoming state
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (next_state == SHIFT);
      done <= (next_state == DONE);
    end
  end

  // operand shifters, borrow flop, counter and partial result
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      bflop  <= 1'b0;
      cnt    <= '0;
    end else if (state == IDLE) begin
      if (start) begin
        a_sr   <= a;
        b_sr   <= b;
        res_sr <= '0;
        bflop  <= 1'b0;
        cnt    <= '0;
      end
    end else if (state == SHIFT) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      res_sr <= {cell_d, res_sr[WIDTH-1:1]};
      bflop  <= cell_bout;
      // counter parks on the last index so it never wraps mid-operation
      if (!last_bit) begin
        cnt <= CW'(cnt + 1'b1);
      end
    end
  end

  // visible result changes only on the completion edge
  always_ff @(posedge clk) begin
    if (rst) begin
      diff   <= '0;
      borrow <= 1'b0;
    end else if (state == SHIFT && last_bit) begin
      diff   <= {cell_d, res_sr[WIDTH-1:1]};
      borrow <= cell_bout;
    end
  end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Self-checking bench for serial_sub_ctrl (WIDTH=8) against an arithmetic reference model.
module tb_serial_sub_ctrl;

  localparam int unsigned WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;

  int unsigned n_checks;
  int unsigned n_errors;

  // reference model: last completed result
  logic [WIDTH-1:0] model_diff;
  logic             model_borrow;
  logic             prev_done;

  serial_sub_ctrl #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // protocol invariants sampled every cycle away from the active edge
  always @(negedge clk) begin
    if (!rst) begin
      check("done_busy_overlap", 32'(done & busy), 32'd0);
      check("done_width", 32'(done & prev_done), 32'd0);
    end
    prev_done = done;
  end

  function automatic void model_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    model_diff   = WIDTH'(int'(x) - int'(y) + 256);
    model_borrow = (x < y);
  endfunction

  // Runs one operation starting at a negedge in IDLE; returns at the negedge of the IDLE cycle after DONE.
  // inj_k >= 0 pulses a spurious start in that SHIFT cycle; inj_done pulses one in the DONE cycle.
  task automatic run_op(input logic [WIDTH-1:0] oa, input logic [WIDTH-1:0] ob,
                        input int inj_k, input bit inj_done);
    a = oa; b = ob; start = 1'b1;
    for (int k = 0; k < WIDTH; k++) begin
      @(negedge clk);
      if (k == 0) begin
        start = 1'b0;
        a = WIDTH'($urandom);
        b = WIDTH'($urandom);
      end
      if (k == inj_k + 1) start = 1'b0;
      check("busy_shift", 32'(busy), 32'd1);
      check("done_shift", 32'(done), 32'd0);
      check("diff_held", 32'(diff), 32'(model_diff));
      check("borrow_held", 32'(borrow), 32'(model_borrow));
      if (k == inj_k) begin
        a = '1; b = '0; start = 1'b1;
      end
    end
    @(negedge clk);
    start = 1'b0;
    model_op(oa, ob);
    check("done_pulse", 32'(done), 32'd1);
    check("busy_done", 32'(busy), 32'd0);
    check("diff", 32'(diff), 32'(model_diff));
    check("borrow", 32'(borrow), 32'(model_borrow));
    if (inj_done) begin
      a = '1; b = '0; start = 1'b1;
    end
    @(negedge clk);
    start = 1'b0;
    check("done_idle", 32'(done), 32'd0);
    check("busy_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    prev_done = 1'b0;
    model_diff = '0; model_borrow = 1'b0;
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_borrow", 32'(borrow), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // directed cases
    run_op(8'h5A, 8'h13, -1, 1'b0);
    check("dir_5a_13", 32'(diff), 32'h47);
    run_op(8'h13, 8'h5A, -1, 1'b0);
    check("dir_13_5a", 32'({borrow, diff}), 32'h1B9);
    run_op(8'h00, 8'h01, -1, 1'b0);
    check("dir_00_01", 32'({borrow, diff}), 32'h1FF);
    run_op(8'h80, 8'h80, -1, 1'b0);
    check("dir_80_80", 32'({borrow, diff}), 32'h000);

    // spurious starts in SHIFT and DONE must be ignored
    run_op(8'h5A, 8'h13, 2, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("ign_busy", 32'(busy), 32'd0);
      check("ign_done", 32'(done), 32'd0);
      check("ign_diff", 32'(diff), 32'h47);
    end

    // reset during the 4th SHIFT cycle aborts the operation
    a = 8'h33; b = 8'h11; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_diff = '0; model_borrow = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_diff", 32'(diff), 32'd0);
    check("abort_borrow", 32'(borrow), 32'd0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("abort_no_done", 32'(done), 32'd0);
    end
    run_op(8'hC3, 8'h3C, -1, 1'b0);

    // start held high: second operation accepted WIDTH+2 cycles after the first
    a = 8'h10; b = 8'h01; start = 1'b1;
    for (int c = 1; c <= 19; c++) begin
      @(negedge clk);
      if (c == 1) begin a = 8'h01; b = 8'h10; end
      if (c == 11) start = 1'b0;
      if (c == 9) check("b2b_first", 32'({done, borrow, diff}), 32'h20F);
      if (c == 10) check("b2b_gap", 32'({busy, done}), 32'd0);
      if (c == 11) check("b2b_accept", 32'(busy), 32'd1);
      if (c == 19) check("b2b_second", 32'({done, borrow, diff}), 32'h3F1);
    end
    model_op(8'h01, 8'h10);
    @(negedge clk);

    // random sweep
    for (int n = 0; n < 1000; n++) begin
      logic [WIDTH-1:0] ra;
      logic [WIDTH-1:0] rb;
      int gap;
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      if (n % 16 == 0) rb = ra;
      run_op(ra, rb, -1, 1'b0);
      gap = int'($urandom_range(2, 0));
      for (int g = 0; g < gap; g++) @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
